// File: rtl/matmul_feeder.sv
// ---------------------------------------------------------------------------
// matmul_feeder
//
// This block feeds operand tiles into an N x N systolic MAC array. It holds
// one signed N x N tile A and one signed N x N tile B. On `start` it clears
// the array accumulators for one cycle. It then streams N operand vectors,
// after which the array holds C = A * B.
//
// The array PEs forward operands combinationally, so no skew is applied. At
// step k the block broadcasts column k of A on `a_in` and row k of B on
// `b_in`, and every PE sees both in the same cycle.
//
// Ports
//   clk          rising-edge clock for all logic
//   rst          synchronous, active-high reset
//   wr_en        write one tile row this cycle (ignored while busy)
//   wr_sel       0 = tile A, 1 = tile B
//   wr_row       row index within the selected tile
//   wr_data      row data; element c at [c*W +: W]
//   start        begin a tile multiply (ignored while busy)
//   busy         a sequence is in progress (CLEAR, STREAM, DONE)
//   done         one-cycle pulse; the array accumulators hold the final C
//   arr_clr      drives the array reset (clears its accumulators)
//   systolic_en  drives the array accumulate enable
//   a_in         element i at [i*W +: W] = A[i][k]
//   b_in         element j at [j*W +: W] = B[k][j]
//
// All outputs are registered. `a_in` and `b_in` are zero outside STREAM.
// ---------------------------------------------------------------------------
module matmul_feeder #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic                 wr_sel,
   input  logic [$clog2(N)-1:0] wr_row,
   input  logic [N*W-1:0]       wr_data,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 arr_clr,
   output logic                 systolic_en,
   output logic [N*W-1:0]       a_in,
   output logic [N*W-1:0]       b_in
);

   localparam int            KW     = $clog2(N);
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_DONE
   } state_t;

   state_t         state;
   logic [KW-1:0]  k;          // step currently presented on a_in / b_in

   // Tile storage: one N*W-bit row per entry, element c at [c*W +: W].
   logic [N*W-1:0] bank_a [N];
   logic [N*W-1:0] bank_b [N];

   // Operands for the step that the next edge registers onto the outputs.
   logic [KW-1:0]  step_next;
   logic [N*W-1:0] col_a_next;
   logic [N*W-1:0] row_b_next;

   // ------------------------------------------------------------------------
   // Next-step operand selection
   // ------------------------------------------------------------------------
   // CLEAR presents step 0 next. STREAM presents step k+1 next. At the last
   // step the wrapped index is never used, because the outputs go to zero.
   // NOTE: every output of this always_comb gets a value on every path before
   // any conditional logic runs, so no latch can be inferred.
   always_comb begin
      step_next  = '0;
      col_a_next = '0;
      row_b_next = '0;
      if (state == S_STREAM) begin
         step_next = k + 1'b1;
      end
      // Column k of A is gathered from element k of every stored row.
      for (int i = 0; i < N; i++) begin
         col_a_next[i*W +: W] = bank_a[i][step_next*W +: W];
      end
      // Row k of B is already stored in the needed layout.
      row_b_next = bank_b[step_next];
   end

   // ------------------------------------------------------------------------
   // Tile banks
   // ------------------------------------------------------------------------
   // Writes are accepted only while idle. A write in the same cycle as the
   // start edge therefore lands before CLEAR, and the stream uses the new
   // data.
   // NOTE: the banks are small register files with an explicit reset. A
   // reset must leave both tiles at zero, so they cannot be mapped to an
   // uninitialised RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < N; r++) begin
            bank_a[r] <= '0;
            bank_b[r] <= '0;
         end
      end else if (wr_en && !busy) begin
         if (wr_sel) begin
            bank_b[wr_row] <= wr_data;
         end else begin
            bank_a[wr_row] <= wr_data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer with registered outputs
   // ------------------------------------------------------------------------
   // Strobes and operand buses default to zero every cycle. Each state then
   // raises only the outputs that belong to the next cycle, so a_in and b_in
   // are zero outside STREAM without any extra logic.
   // NOTE: all state and output registers use non-blocking assignments. Every
   // right-hand side then sees the pre-edge values, whatever order the
   // statements appear in.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         k           <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         arr_clr     <= 1'b0;
         systolic_en <= 1'b0;
         a_in        <= '0;
         b_in        <= '0;
      end else begin
         done        <= 1'b0;
         arr_clr     <= 1'b0;
         systolic_en <= 1'b0;
         a_in        <= '0;
         b_in        <= '0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_CLEAR;
                  busy    <= 1'b1;
                  arr_clr <= 1'b1;
               end
            end

            S_CLEAR: begin
               state       <= S_STREAM;
               k           <= '0;
               systolic_en <= 1'b1;
               a_in        <= col_a_next;
               b_in        <= row_b_next;
            end

            S_STREAM: begin
               if (k == K_LAST) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  k           <= step_next;
                  systolic_en <= 1'b1;
                  a_in        <= col_a_next;
                  b_in        <= row_b_next;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               k     <= '0;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               k     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_feeder.sv
// ---------------------------------------------------------------------------
// tb_matmul_feeder
//
// Self-checking bench for matmul_feeder with N=4 and W=8.
//
// The bench keeps the intended tiles as integer matrices (ma, mb). It derives
// every expected operand vector and the expected product C = A*B from them
// with plain arithmetic.
//
// A behavioural model of the downstream array sits on the DUT outputs. It
// clears on arr_clr and accumulates on systolic_en. Its accumulators are
// compared with the reference product in the DONE cycle.
//
// Inputs are driven on falling edges, and outputs are sampled on falling
// edges as well.
// ---------------------------------------------------------------------------
module tb_matmul_feeder;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int KW = $clog2(N);

   logic           clk;
   logic           rst;
   logic           wr_en;
   logic           wr_sel;
   logic [KW-1:0]  wr_row;
   logic [N*W-1:0] wr_data;
   logic           start;
   logic           busy;
   logic           done;
   logic           arr_clr;
   logic           systolic_en;
   logic [N*W-1:0] a_in;
   logic [N*W-1:0] b_in;

   int checks_total  = 0;
   int checks_passed = 0;

   // Intended tile contents (reference model of the banks).
   int ma [N][N];
   int mb [N][N];

   // Downstream array model.
   int acc [N][N];

   matmul_feeder #(.N(N), .W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_sel      (wr_sel),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .arr_clr     (arr_clr),
      .systolic_en (systolic_en),
      .a_in        (a_in),
      .b_in        (b_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Array: rst clears the accumulators; systolic_en accumulates signed products.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (arr_clr)
               acc[i][j] <= 0;
            else if (systolic_en)
               acc[i][j] <= acc[i][j] + int'($signed(a_in[i*W +: W])) * int'($signed(b_in[j*W +: W]));
         end
      end
   end

   // Watchdog: the bench must always end on its own.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   // Helpers (stimulus and reference arithmetic only)
   // ------------------------------------------------------------------------
   function automatic logic [N*W-1:0] pack_row(input bit sel, input int r);
      logic [N*W-1:0] v;
      v = '0;
      for (int c = 0; c < N; c++)
         v[c*W +: W] = sel ? W'(mb[r][c]) : W'(ma[r][c]);
      return v;
   endfunction

   function automatic int ref_c(input int i, input int j);
      int s;
      s = 0;
      for (int kk = 0; kk < N; kk++)
         s += ma[i][kk] * mb[kk][j];
      return s;
   endfunction

   function automatic int rand_s8();
      return int'($urandom_range(255)) - 128;
   endfunction

   // One row write per cycle; called and returns right after a falling edge.
   task automatic write_row(input bit sel, input int r);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_row  = KW'(r);
      wr_data = pack_row(sel, r);
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic load_all();
      for (int r = 0; r < N; r++) begin
         write_row(1'b0, r);
         write_row(1'b1, r);
      end
   endtask

   // ------------------------------------------------------------------------
   // One full sequence with cycle-exact checks.
   //
   // The task is entered right after a falling edge while the DUT is idle.
   // start is raised now and sampled at the next rising edge (E0). The task
   // returns during cycle N+3, when busy is low, so start can be raised again
   // at once.
   //
   // same_wr: write B row 3 = all 1s in the same cycle as start.
   // disturb: during STREAM (k=1) raise start and write A row 0 = all 7s;
   //          both must be ignored.
   // ------------------------------------------------------------------------
   task automatic run_tile(input string name, input bit same_wr, input bit disturb);
      logic [N*W-1:0] ea;
      logic [N*W-1:0] eb;
      int             bad;
      int             bad_i;
      int             bad_j;

      if (same_wr) begin
         for (int j = 0; j < N; j++)
            mb[3][j] = 1;
         wr_en   = 1'b1;
         wr_sel  = 1'b1;
         wr_row  = KW'(3);
         wr_data = pack_row(1'b1, 3);
      end
      start = 1'b1;

      // Cycle 1: CLEAR.
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      checks_total++;
      if (arr_clr !== 1'b1 || busy !== 1'b1 || systolic_en !== 1'b0 || done !== 1'b0)
         $display("FAIL %s clear cycle: got clr=%b busy=%b en=%b done=%b expected clr=1 busy=1 en=0 done=0",
                  name, arr_clr, busy, systolic_en, done);
      else
         checks_passed++;

      // Cycles 2..N+1: STREAM steps k = 0..N-1.
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         if (disturb && k == 2) begin
            start = 1'b0;
            wr_en = 1'b0;
         end
         ea = '0;
         eb = '0;
         for (int i = 0; i < N; i++) begin
            ea[i*W +: W] = W'(ma[i][k]);
            eb[i*W +: W] = W'(mb[k][i]);
         end
         checks_total++;
         if (systolic_en !== 1'b1 || arr_clr !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
            $display("FAIL %s stream ctl k=%0d: got en=%b clr=%b done=%b busy=%b expected en=1 clr=0 done=0 busy=1",
                     name, k, systolic_en, arr_clr, done, busy);
         else
            checks_passed++;
         checks_total++;
         if (a_in !== ea)
            $display("FAIL %s a_in k=%0d: got %h expected %h", name, k, a_in, ea);
         else
            checks_passed++;
         checks_total++;
         if (b_in !== eb)
            $display("FAIL %s b_in k=%0d: got %h expected %h", name, k, b_in, eb);
         else
            checks_passed++;
         if (disturb && k == 1) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_row  = '0;
            wr_data = '0;
            for (int c = 0; c < N; c++)
               wr_data[c*W +: W] = W'(7);
         end
      end

      // Cycle N+2: DONE, with the final C in the array.
      @(negedge clk);
      checks_total++;
      if (done !== 1'b1 || busy !== 1'b1 || systolic_en !== 1'b0 || a_in !== '0 || b_in !== '0)
         $display("FAIL %s done cycle: got done=%b busy=%b en=%b a=%h b=%h expected done=1 busy=1 en=0 a=0 b=0",
                  name, done, busy, systolic_en, a_in, b_in);
      else
         checks_passed++;

      bad   = 0;
      bad_i = 0;
      bad_j = 0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (acc[i][j] !== ref_c(i, j)) begin
               if (bad == 0) begin
                  bad_i = i;
                  bad_j = j;
               end
               bad++;
            end
         end
      end
      checks_total++;
      if (bad != 0)
         $display("FAIL %s C[%0d][%0d] (%0d wrong): got %0d expected %0d",
                  name, bad_i, bad_j, bad, acc[bad_i][bad_j], ref_c(bad_i, bad_j));
      else
         checks_passed++;

      // Cycle N+3: back in IDLE.
      @(negedge clk);
      checks_total++;
      if (busy !== 1'b0 || done !== 1'b0 || arr_clr !== 1'b0)
         $display("FAIL %s idle after done: got busy=%b done=%b clr=%b expected 0 0 0",
                  name, busy, done, arr_clr);
      else
         checks_passed++;
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_sel  = 1'b0;
      wr_row  = '0;
      wr_data = '0;
      start   = 1'b0;
      repeat (3) @(negedge clk);
      checks_total++;
      if (busy !== 1'b0 || done !== 1'b0 || arr_clr !== 1'b0 || systolic_en !== 1'b0 ||
          a_in !== '0 || b_in !== '0)
         $display("FAIL reset outputs: got busy=%b done=%b clr=%b en=%b a=%h b=%h expected all 0",
                  busy, done, arr_clr, systolic_en, a_in, b_in);
      else
         checks_passed++;
      rst = 1'b0;
      @(negedge clk);
      checks_total++;
      if (busy !== 1'b0 || arr_clr !== 1'b0)
         $display("FAIL reset idle hold: got busy=%b clr=%b expected 0 0", busy, arr_clr);
      else
         checks_passed++;
   endtask

   task automatic test_identity();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = (i == j) ? 1 : 0;
            mb[i][j] = i * N + j + 1;
         end
      load_all();
      run_tile("identity", 1'b0, 1'b0);
   endtask

   task automatic test_signed_extremes();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = -128;
            mb[i][j] = -128;
         end
      load_all();
      run_tile("extreme_neg_neg", 1'b0, 1'b0);
      checks_total++;
      if (acc[2][1] !== 65536)
         $display("FAIL extreme_neg_neg value: got %0d expected 65536", acc[2][1]);
      else
         checks_passed++;

      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            ma[i][j] = 127;
      load_all();
      run_tile("extreme_pos_neg", 1'b0, 1'b0);
      checks_total++;
      if (acc[0][3] !== -65024)
         $display("FAIL extreme_pos_neg value: got %0d expected -65024", acc[0][3]);
      else
         checks_passed++;
   endtask

   task automatic test_random();
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               ma[i][j] = rand_s8();
               mb[i][j] = rand_s8();
            end
         load_all();
         run_tile("random", 1'b0, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = rand_s8();
            mb[i][j] = rand_s8();
         end
      load_all();
      run_tile("b2b_first", 1'b0, 1'b0);
      // start is raised in the first idle cycle (N+3).
      run_tile("b2b_second", 1'b0, 1'b0);
   endtask

   task automatic test_protection();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = rand_s8();
            mb[i][j] = rand_s8();
         end
      // Keep row 0 of A distinct from the all-7s intrusion.
      ma[0][0] = -5;
      load_all();
      run_tile("protect_disturbed", 1'b0, 1'b1);
      // No restart may follow from the ignored start.
      @(negedge clk);
      checks_total++;
      if (busy !== 1'b0 || arr_clr !== 1'b0)
         $display("FAIL protect no restart: got busy=%b clr=%b expected 0 0", busy, arr_clr);
      else
         checks_passed++;
      run_tile("protect_rerun", 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int done_seen;
      int busy_seen;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = rand_s8() | 1;
            mb[i][j] = rand_s8() | 1;
         end
      load_all();
      start = 1'b1;
      @(negedge clk);                // cycle 1: CLEAR
      start = 1'b0;
      repeat (3) @(negedge clk);     // cycle 4: STREAM step k=2
      checks_total++;
      if (systolic_en !== 1'b1)
         $display("FAIL reset_mid precondition: got en=%b expected 1", systolic_en);
      else
         checks_passed++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks_total++;
      if (busy !== 1'b0 || done !== 1'b0 || arr_clr !== 1'b0 || systolic_en !== 1'b0 ||
          a_in !== '0 || b_in !== '0)
         $display("FAIL reset_mid outputs: got busy=%b done=%b clr=%b en=%b a=%h b=%h expected all 0",
                  busy, done, arr_clr, systolic_en, a_in, b_in);
      else
         checks_passed++;
      done_seen = 0;
      busy_seen = 0;
      for (int c = 0; c < N + 4; c++) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
         if (busy === 1'b1) busy_seen++;
      end
      checks_total++;
      if (done_seen != 0 || busy_seen != 0)
         $display("FAIL reset_mid no done: got done_cycles=%0d busy_cycles=%0d expected 0 0",
                  done_seen, busy_seen);
      else
         checks_passed++;
      // The banks now read zero; the stream must carry zeros and C must be zero.
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = 0;
            mb[i][j] = 0;
         end
      run_tile("reset_mid_banks_zero", 1'b0, 1'b0);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = rand_s8();
            mb[i][j] = rand_s8();
         end
      load_all();
      run_tile("reset_mid_reload", 1'b0, 1'b0);
   endtask

   task automatic test_same_cycle_write();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = rand_s8();
            mb[i][j] = rand_s8();
         end
      mb[3][0] = 50;   // make the row-3 rewrite observable
      load_all();
      run_tile("same_cycle_write", 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_identity();
      test_signed_extremes();
      test_random();
      test_back_to_back();
      test_protection();
      test_reset_mid();
      test_same_cycle_write();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
